// File: rtl/vga_interface_pkg.sv
// Shared VGA timing defaults, counter width and pipeline record for vga_interface.
// Sync windows are inclusive [lo, hi] bounds on the 10-bit h/v counters.
package vga_interface_pkg;

  localparam int CNT_W = 10;

  localparam int PIX_DIV_DEF = 4;
  localparam int H_VIS_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_VIS_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HS_LO_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int HS_HI_DEF = HS_LO_DEF + H_SYNC_DEF - 1;
  localparam int VS_LO_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int VS_HI_DEF = VS_LO_DEF + V_SYNC_DEF - 1;

  typedef struct packed {
    logic             vis;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } stage0_t;

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/generic_counter.sv
// Free-running modulo counter; o_trig is a 1-cycle pulse on the terminal count.
// Used as the pixel-enable divider in vga_interface.
module generic_counter #(
  parameter int COUNTER_WIDTH = 2,
  parameter int COUNTER_MAX   = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_trig
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_C = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == MAX_C) ? '0 : r_count + 1'b1;
    end
  end

  assign o_trig = i_enable && (r_count == MAX_C);

endmodule

// File: rtl/vga_interface.sv
// VGA timing generator: h/v counters, registered pixel address (stage 0), and
// registered colour/sync outputs one pixel later (stage 1) so all pins stay aligned.
module vga_interface
  import vga_interface_pkg::*;
#(
  parameter int PIX_DIV = PIX_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [11:0] i_colour_in,
  output logic [9:0]  o_addrh,
  output logic [8:0]  o_addrv,
  output logic [11:0] o_colour_out,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = ($clog2(PIX_DIV) < 2) ? 2 : $clog2(PIX_DIV);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic             w_pix_en;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_vis;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  stage0_t          r_s0;
  logic [9:0]       r_addrh;
  logic [8:0]       r_addrv;
  logic [11:0]      r_colour;
  logic             r_hs;
  logic             r_vs;
  logic             r_frame_start;

  generic_counter #(
    .COUNTER_WIDTH(DIV_W),
    .COUNTER_MAX  (PIX_DIV - 1)
  ) u_pix_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(1'b1),
    .o_trig  (w_pix_en)
  );

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_vis    = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Stage 0: address to the renderer, plus copies for stage 1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addrh <= '0;
      r_addrv <= '0;
      r_s0    <= '0;
    end else if (w_pix_en) begin
      r_addrh <= w_vis ? r_h_cnt : 10'd0;
      r_addrv <= w_vis ? r_v_cnt[8:0] : 9'd0;
      r_s0    <= '{vis: w_vis, h: r_h_cnt, v: r_v_cnt};
    end
  end

  // Stage 1: renderer colour has had PIX_DIV-1 cycles to settle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_colour <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
    end else if (w_pix_en) begin
      r_colour <= r_s0.vis ? i_colour_in : 12'd0;
      r_hs     <= ~in_window(r_s0.h, HS_LO, HS_HI);
      r_vs     <= ~in_window(r_s0.v, VS_LO, VS_HI);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && w_h_last && w_v_last;
    end
  end

  assign o_addrh       = r_addrh;
  assign o_addrv       = r_addrv;
  assign o_colour_out  = r_colour;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_interface.sv
// Bench for vga_interface: default 640x480 build, PIX_DIV=2 build and a shrunken
// geometry (for whole-frame checks) are compared every cycle against a time-based model.
module tb_vga_interface;

  typedef struct {
    int pd, hvis, hfp, hsync, hbp, vvis, vfp, vsync, vbp;
  } geom_t;

  typedef struct packed {
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic [11:0] colour;
    logic        hs;
    logic        vs;
    logic        fs;
  } obs_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [11:0] col_a = '0, col_b = '0, col_c = '0;
  logic [9:0]  addrh_a, addrh_b, addrh_c;
  logic [8:0]  addrv_a, addrv_b, addrv_c;
  logic [11:0] cout_a, cout_b, cout_c;
  logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, fs_a, fs_b, fs_c;

  vga_interface u_dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_colour_in(col_a),
    .o_addrh(addrh_a), .o_addrv(addrv_a), .o_colour_out(cout_a),
    .o_hs(hs_a), .o_vs(vs_a), .o_frame_start(fs_a)
  );

  vga_interface #(.PIX_DIV(2)) u_dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_colour_in(col_b),
    .o_addrh(addrh_b), .o_addrv(addrv_b), .o_colour_out(cout_b),
    .o_hs(hs_b), .o_vs(vs_b), .o_frame_start(fs_b)
  );

  vga_interface #(
    .PIX_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut_c (
    .i_clk(clk), .i_reset(rst_c), .i_colour_in(col_c),
    .o_addrh(addrh_c), .o_addrv(addrv_c), .o_colour_out(cout_c),
    .o_hs(hs_c), .o_vs(vs_c), .o_frame_start(fs_c)
  );

  logic [11:0] lut [128];
  int n_cmp = 0;
  int n_bad = 0;
  int n_cur [3];
  int q_hs_fall[$], q_hs_rise[$], q_vs_fall[$], q_vs_rise[$], q_fs[$];
  int fs_hi;

  function automatic logic [11:0] render(input int sel, input logic [9:0] h, input logic [8:0] v);
    if (sel == 2) return lut[{v[2:0], h[3:0]}];
    if (h == 10'd0 && v == 9'd0) return 12'hFFF;
    return {2'b00, h};
  endfunction

  // Renderer with one cycle of registered latency, like snake_control.
  always @(posedge clk) begin
    col_a <= render(0, addrh_a, addrv_a);
    col_b <= render(1, addrh_b, addrv_b);
    col_c <= render(2, addrh_c, addrv_c);
  end

  function automatic geom_t geom(input int sel);
    geom_t g;
    case (sel)
      0:       g = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
      1:       g = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
      default: g = '{4, 16, 2, 4, 3, 6, 1, 2, 2};
    endcase
    return g;
  endfunction

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0:       o = {addrh_a, addrv_a, cout_a, hs_a, vs_a, fs_a};
      1:       o = {addrh_b, addrv_b, cout_b, hs_b, vs_b, fs_b};
      default: o = {addrh_c, addrv_c, cout_c, hs_c, vs_c, fs_c};
    endcase
    return o;
  endfunction

  // Expected outputs n clocks after the reset edge: after p pixel enables the
  // address shows pixel p-1 and colour/sync show pixel p-2 in raster order.
  function automatic obs_t model(input int sel, input int n);
    geom_t g;
    obs_t  e;
    int    htot, vtot, p, q, h, v;
    bit    vis;
    g    = geom(sel);
    htot = g.hvis + g.hfp + g.hsync + g.hbp;
    vtot = g.vvis + g.vfp + g.vsync + g.vbp;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    p    = n / g.pd;
    if (p >= 1) begin
      q = p - 1;
      h = q % htot;
      v = (q / htot) % vtot;
      if (h < g.hvis && v < g.vvis) begin
        e.addrh = 10'(h);
        e.addrv = 9'(v);
      end
    end
    if (p >= 2) begin
      q   = p - 2;
      h   = q % htot;
      v   = (q / htot) % vtot;
      vis = (h < g.hvis) && (v < g.vvis);
      e.hs = !(h >= g.hvis + g.hfp && h < g.hvis + g.hfp + g.hsync);
      e.vs = !(v >= g.vvis + g.vfp && v < g.vvis + g.vfp + g.vsync);
      e.colour = vis ? render(sel, 10'(h), 9'(v)) : 12'h000;
    end
    e.fs = (n > 0) && (n % g.pd == 0) && (p % (htot * vtot) == 0);
    return e;
  endfunction

  task automatic check_obs(input string name, input int n, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d got h=%0d v=%0d col=%h hs=%b vs=%b fs=%b expected h=%0d v=%0d col=%h hs=%b vs=%b fs=%b",
               name, n, got.addrh, got.addrv, got.colour, got.hs, got.vs, got.fs,
               exp.addrh, exp.addrv, exp.colour, exp.hs, exp.vs, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_q();
    q_hs_fall.delete(); q_hs_rise.delete();
    q_vs_fall.delete(); q_vs_rise.delete();
    q_fs.delete();
    fs_hi = 0;
  endtask

  task automatic do_reset(input int sel);
    @(negedge clk);
    case (sel) 0: rst_a = 1'b1; 1: rst_b = 1'b1; default: rst_c = 1'b1; endcase
    @(negedge clk);
    case (sel) 0: rst_a = 1'b0; 1: rst_b = 1'b0; default: rst_c = 1'b0; endcase
    n_cur[sel] = 0;
    clear_q();
    check_obs("reset_state", 0, get_obs(sel), {10'd0, 9'd0, 12'h000, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic run(input int sel, input int ncyc);
    obs_t prev, o;
    for (int i = 0; i < ncyc; i++) begin
      prev = get_obs(sel);
      @(negedge clk);
      n_cur[sel]++;
      o = get_obs(sel);
      check_obs("model", n_cur[sel], o, model(sel, n_cur[sel]));
      if (prev.hs && !o.hs) q_hs_fall.push_back(n_cur[sel]);
      if (!prev.hs && o.hs) q_hs_rise.push_back(n_cur[sel]);
      if (prev.vs && !o.vs) q_vs_fall.push_back(n_cur[sel]);
      if (!prev.vs && o.vs) q_vs_rise.push_back(n_cur[sel]);
      if (o.fs) fs_hi++;
      if (!prev.fs && o.fs) q_fs.push_back(n_cur[sel]);
    end
  endtask

  task automatic check_line(input string tag, input int first_fall, input int period, input int low);
    check_int({tag, "_hs_falls"}, q_hs_fall.size(), 2);
    check_int({tag, "_hs_rises"}, q_hs_rise.size(), 2);
    if (q_hs_fall.size() >= 2 && q_hs_rise.size() >= 1) begin
      check_int({tag, "_hs_first_fall"}, q_hs_fall[0], first_fall);
      check_int({tag, "_hs_period"}, q_hs_fall[1] - q_hs_fall[0], period);
      check_int({tag, "_hs_low"}, q_hs_rise[0] - q_hs_fall[0], low);
    end
  endtask

  function automatic obs_t mk(input int h, input int v, input logic [11:0] c, input logic hs, input logic vs);
    return {10'(h), 9'(v), c, hs, vs, 1'b0};
  endfunction

  initial begin
    vec_t tbl[$];

    for (int i = 0; i < 128; i++) lut[i] = 12'($urandom);
    lut[0] = 12'hFFF;

    tbl.push_back('{0,    mk(0,   0, 12'h000, 1, 1)});
    tbl.push_back('{3,    mk(0,   0, 12'h000, 1, 1)});
    tbl.push_back('{8,    mk(1,   0, 12'hFFF, 1, 1)});
    tbl.push_back('{11,   mk(1,   0, 12'hFFF, 1, 1)});
    tbl.push_back('{12,   mk(2,   0, 12'h001, 1, 1)});
    tbl.push_back('{2560, mk(639, 0, 12'h27E, 1, 1)});
    tbl.push_back('{2564, mk(0,   0, 12'h27F, 1, 1)});
    tbl.push_back('{2568, mk(0,   0, 12'h000, 1, 1)});
    tbl.push_back('{2631, mk(0,   0, 12'h000, 1, 1)});
    tbl.push_back('{2632, mk(0,   0, 12'h000, 0, 1)});
    tbl.push_back('{3015, mk(0,   0, 12'h000, 0, 1)});
    tbl.push_back('{3016, mk(0,   0, 12'h000, 1, 1)});
    tbl.push_back('{3204, mk(0,   1, 12'h000, 1, 1)});
    tbl.push_back('{3208, mk(1,   1, 12'h000, 1, 1)});
    tbl.push_back('{3212, mk(2,   1, 12'h001, 1, 1)});

    repeat (3) @(negedge clk);

    // Default build: boundary table, then two full lines of HS timing.
    do_reset(0);
    foreach (tbl[i]) begin
      run(0, tbl[i].n - n_cur[0]);
      check_obs("table", tbl[i].n, get_obs(0), tbl[i].exp);
    end
    run(0, 6420 - n_cur[0]);
    check_line("a", 2632, 3200, 384);

    // Abort at h=300 of line 2, then the same line timing must repeat.
    run(0, 4 * (1600 + 300 + 1) + 2 - n_cur[0]);
    do_reset(0);
    run(0, 6420);
    check_line("a_rst", 2632, 3200, 384);

    // PIX_DIV=2 build with the registered renderer.
    do_reset(1);
    run(1, 3300);
    check_line("b", 1316, 1600, 192);

    // Small geometry: whole frames, vertical blanking and frame strobe.
    do_reset(2);
    run(2, 3320);
    check_int("c_vs_falls", q_vs_fall.size(), 3);
    check_int("c_vs_rises", q_vs_rise.size(), 3);
    check_int("c_fs_pulses", q_fs.size(), 3);
    check_int("c_fs_width", fs_hi, 3);
    if (q_vs_fall.size() >= 2 && q_vs_rise.size() >= 1) begin
      check_int("c_vs_first_fall", q_vs_fall[0], 708);
      check_int("c_vs_period", q_vs_fall[1] - q_vs_fall[0], 1100);
      check_int("c_vs_low", q_vs_rise[0] - q_vs_fall[0], 200);
    end
    if (q_fs.size() >= 2) begin
      check_int("c_fs_first", q_fs[0], 1100);
      check_int("c_fs_period", q_fs[1] - q_fs[0], 1100);
    end

    // Random reset points anywhere in the frame.
    for (int k = 0; k < 6; k++) begin
      run(2, int'($urandom_range(1500, 30)));
      do_reset(2);
    end
    run(2, 1200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
